uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter between NUM_REQ byte-stream requesters
//  (status reporter, debug dump, echo, ...). Grants are message-atomic: the

---
 rtl/uart_tx_arbiter.sv | 69 ++++++
 tb/tb_uart_tx_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-atomic round-robin share of one UART transmitter with an idle gap after each message
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DELAY_BIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = DELAY_BIT < 1 ? 1 : DELAY_BIT;
    localparam logic [CW-1:0] GAP_LOAD = CW'((1 << DELAY_BIT) - 1);
    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;
    state_t              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [PW-1:0]       ptr_q;
    logic [CW-1:0]       cnt_q;
    logic [PW-1:0]       win;
    logic [PW-1:0]       idx;
    logic                stream;
    // Scan downward so the last hit is the nearest requester after ptr_q.
    always_comb begin
        win = ptr_q;
        idx = ptr_q;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (req_valid[idx]) win = idx;
        end
    end
    assign stream    = state_q == STREAM;
    assign tx_valid  = stream & req_valid[ptr_q];
    assign tx_data   = stream ? req_data[{ptr_q, 3'b000} +: 8] : 8'h00;
    assign req_ready = stream && tx_ready ? grant_q : '0;
    assign grant     = grant_q;
    assign busy      = state_q != IDLE;
    // In STREAM the owner index is ptr_q, since ptr_q is loaded with the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (|req_valid) begin
                    grant_q <= NUM_REQ'(1) << win;
                    ptr_q   <= win;
                    state_q <= STREAM;
                end
                STREAM: if (tx_valid && tx_ready && req_last[ptr_q]) begin
                    grant_q <= '0;
                    cnt_q   <= GAP_LOAD;
                    state_q <= GAP;
                end
                GAP: if (cnt_q == '0) state_q <= IDLE;
                     else cnt_q <= cnt_q - 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, streaming, gap timing and reset for both gap settings
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        tx_ready;
    logic [3:0]  req_ready, grant, req_ready0, grant0;
    logic [7:0]  tx_data, tx_data0;
    logic        tx_valid, busy, tx_valid0, busy0;
    int          vec = 0;
    int          miss = 0;
    int          cnt;
    logic [7:0]  log_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .DELAY_BIT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant(grant), .busy(busy));

    uart_tx_arbiter #(.NUM_REQ(4), .DELAY_BIT(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready0), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .grant(grant0), .busy(busy0));

    task automatic set_byte(input int i, input logic [7:0] d, input logic l);
        req_data[8*i +: 8] = d;
        req_last[i] = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        req_last = 4'b1111;
        req_data = 32'hDEADBEEF;
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vec++; if (grant !== 4'b0000) begin miss++; $display("FAIL rst_grant got=%b exp=0000", grant); end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL rst_busy got=%b exp=0", busy); end
        vec++; if (tx_valid !== 1'b0) begin miss++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        vec++; if (req_ready !== 4'b0000) begin miss++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
        vec++; if (tx_data !== 8'h00) begin miss++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    endtask

    task automatic test_single_msg();
        do_reset();
        req_valid = 4'b0001;
        set_byte(0, "H", 1'b0);
        #1;
        vec++; if (grant !== 4'b0000 || tx_valid !== 1'b0) begin miss++; $display("FAIL t1_latency grant=%b tx_valid=%b exp 0000/0", grant, tx_valid); end
        @(negedge clk); #1;
        vec++; if (grant !== 4'b0001) begin miss++; $display("FAIL t1_grant got=%b exp=0001", grant); end
        vec++; if (tx_valid !== 1'b1 || tx_data !== "H" || req_ready !== 4'b0001) begin miss++; $display("FAIL t1_byte0 valid=%b data=%h ready=%b exp 1/48/0001", tx_valid, tx_data, req_ready); end
        @(negedge clk); set_byte(0, "i", 1'b0); #1;
        vec++; if (tx_valid !== 1'b1 || tx_data !== "i") begin miss++; $display("FAIL t1_byte1 valid=%b data=%h exp 1/69", tx_valid, tx_data); end
        @(negedge clk); set_byte(0, 8'h0A, 1'b1); #1;
        vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h0A || busy !== 1'b1) begin miss++; $display("FAIL t1_byte2 valid=%b data=%h busy=%b exp 1/0a/1", tx_valid, tx_data, busy); end
        @(negedge clk); req_valid = '0; req_last = '0; #1;
        for (int k = 0; k < 16; k++) begin
            vec++; if (busy !== 1'b1 || grant !== 4'b0000 || tx_valid !== 1'b0) begin miss++; $display("FAIL t1_gap%0d busy=%b grant=%b tx_valid=%b exp 1/0000/0", k, busy, grant, tx_valid); end
            @(negedge clk); #1;
        end
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL t1_gap_end busy=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req_valid = 4'b1111;
        req_last = 4'b1111;
        for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'hA0 + 8'(i);
        @(negedge clk); #1;
        vec++; if (grant !== 4'b0001 || tx_data !== 8'hA0) begin miss++; $display("FAIL t2_first grant=%b data=%h exp 0001/a0", grant, tx_data); end
        for (int m = 1; m <= 4; m++) begin
            exp_g = 4'b0001 << (m % 4);
            cnt = 0;
            do begin @(negedge clk); #1; cnt++; end while (grant === 4'b0000 && cnt < 40);
            vec++; if (cnt !== 18) begin miss++; $display("FAIL t2_spacing%0d got=%0d exp=18", m, cnt); end
            vec++; if (grant !== exp_g || tx_data !== 8'hA0 + 8'(m % 4)) begin miss++; $display("FAIL t2_grant%0d grant=%b data=%h exp %b/%h", m, grant, tx_data, exp_g, 8'hA0 + 8'(m % 4)); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d[4]  = '{8'h11, 8'h22, 8'h22, 8'h33};
        logic       l[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       r[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] er[4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001};
        do_reset();
        log_q.delete();
        req_valid = 4'b0101;
        set_byte(0, 8'h11, 1'b0);
        set_byte(2, 8'h77, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            set_byte(0, d[c], l[c]);
            tx_ready = r[c];
            #1;
            vec++; if (grant !== 4'b0001 || req_ready !== er[c] || tx_data !== d[c]) begin miss++; $display("FAIL t3_cyc%0d grant=%b ready=%b data=%h exp 0001/%b/%h", c, grant, req_ready, tx_data, er[c], d[c]); end
            if (tx_valid && tx_ready) log_q.push_back(tx_data);
        end
        @(negedge clk); req_valid[0] = 1'b0; tx_ready = 1'b1; #1;
        cnt = 1;
        while (grant === 4'b0000 && cnt < 40) begin
            vec++; if (req_ready !== 4'b0000) begin miss++; $display("FAIL t3_wait%0d ready=%b exp=0000", cnt, req_ready); end
            @(negedge clk); #1; cnt++;
        end
        vec++; if (cnt !== 18 || grant !== 4'b0100 || tx_data !== 8'h77) begin miss++; $display("FAIL t3_handover cnt=%0d grant=%b data=%h exp 18/0100/77", cnt, grant, tx_data); end
        vec++; if (log_q.size() !== 3) begin miss++; $display("FAIL t3_count got=%0d exp=3", log_q.size()); end
        else begin
            vec++; if (log_q[0] !== 8'h11 || log_q[1] !== 8'h22 || log_q[2] !== 8'h33) begin miss++; $display("FAIL t3_order got=%h %h %h exp 11 22 33", log_q[0], log_q[1], log_q[2]); end
        end
    endtask

    task automatic test_owner_stall();
        do_reset();
        req_valid = 4'b0011;
        set_byte(0, 8'hA1, 1'b0);
        set_byte(1, 8'hB1, 1'b1);
        @(negedge clk); #1;
        vec++; if (grant !== 4'b0001 || tx_valid !== 1'b1 || tx_data !== 8'hA1) begin miss++; $display("FAIL t4_first grant=%b valid=%b data=%h exp 0001/1/a1", grant, tx_valid, tx_data); end
        @(negedge clk); req_valid[0] = 1'b0; set_byte(0, 8'hA2, 1'b1); #1;
        for (int k = 0; k < 10; k++) begin
            vec++; if (tx_valid !== 1'b0 || grant !== 4'b0001 || req_ready !== 4'b0001) begin miss++; $display("FAIL t4_stall%0d valid=%b grant=%b ready=%b exp 0/0001/0001", k, tx_valid, grant, req_ready); end
            @(negedge clk); #1;
        end
        req_valid[0] = 1'b1; #1;
        vec++; if (tx_valid !== 1'b1 || tx_data !== 8'hA2 || grant !== 4'b0001) begin miss++; $display("FAIL t4_resume valid=%b data=%h grant=%b exp 1/a2/0001", tx_valid, tx_data, grant); end
        @(negedge clk); req_valid[0] = 1'b0; #1;
        cnt = 1;
        while (grant === 4'b0000 && cnt < 40) begin @(negedge clk); #1; cnt++; end
        vec++; if (cnt !== 18 || grant !== 4'b0010 || tx_data !== 8'hB1) begin miss++; $display("FAIL t4_next cnt=%0d grant=%b data=%h exp 18/0010/b1", cnt, grant, tx_data); end
    endtask

    task automatic test_reset_mid_msg();
        do_reset();
        req_valid = 4'b0001;
        set_byte(0, 8'hC1, 1'b0);
        @(negedge clk); #1;
        vec++; if (tx_data !== 8'hC1 || tx_valid !== 1'b1) begin miss++; $display("FAIL t5_byte1 data=%h valid=%b exp c1/1", tx_data, tx_valid); end
        @(negedge clk); set_byte(0, 8'hC2, 1'b0); #1;
        vec++; if (tx_data !== 8'hC2 || tx_valid !== 1'b1) begin miss++; $display("FAIL t5_byte2 data=%h valid=%b exp c2/1", tx_data, tx_valid); end
        rst = 1'b1;
        @(negedge clk); #1;
        vec++; if (grant !== 4'b0000 || tx_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin miss++; $display("FAIL t5_abort grant=%b valid=%b busy=%b ready=%b exp 0000/0/0/0000", grant, tx_valid, busy, req_ready); end
        rst = 1'b0;
        req_valid = 4'b0110;
        set_byte(1, 8'hD1, 1'b1);
        set_byte(2, 8'hE1, 1'b1);
        @(negedge clk); #1;
        vec++; if (grant !== 4'b0010 || tx_data !== 8'hD1) begin miss++; $display("FAIL t5_regrant grant=%b data=%h exp 0010/d1", grant, tx_data); end
    endtask

    task automatic test_min_gap();
        do_reset();
        req_valid = 4'b0001;
        set_byte(0, 8'hF1, 1'b1);
        @(negedge clk); #1;
        vec++; if (grant0 !== 4'b0001 || tx_valid0 !== 1'b1 || tx_data0 !== 8'hF1) begin miss++; $display("FAIL t6_grant grant=%b valid=%b data=%h exp 0001/1/f1", grant0, tx_valid0, tx_data0); end
        @(negedge clk); req_valid = 4'b0010; set_byte(1, 8'hF2, 1'b1); #1;
        vec++; if (busy0 !== 1'b1 || grant0 !== 4'b0000 || tx_valid0 !== 1'b0) begin miss++; $display("FAIL t6_gap busy=%b grant=%b valid=%b exp 1/0000/0", busy0, grant0, tx_valid0); end
        @(negedge clk); #1;
        vec++; if (busy0 !== 1'b0 || grant0 !== 4'b0000) begin miss++; $display("FAIL t6_idle busy=%b grant=%b exp 0/0000", busy0, grant0); end
        @(negedge clk); #1;
        vec++; if (grant0 !== 4'b0010 || tx_data0 !== 8'hF2) begin miss++; $display("FAIL t6_next grant=%b data=%h exp 0010/f2", grant0, tx_data0); end
    endtask

    initial begin
        test_reset();
        test_single_msg();
        test_round_robin();
        test_backpressure();
        test_owner_stall();
        test_reset_mid_msg();
        test_min_gap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
